// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer between commit and the CSR file.
// It synchronises and latches the timer, software and external interrupts.
// At an instruction boundary it writes mepc, mcause and mstatus, one per cycle, then redirects fetch.
// It also sequences mret: restore mstatus, then jump to mepc.
//
//   state     | meaning
//   ----------+----------------------------------------------------
//   S_IDLE    | waiting for a commit; no stall
//   S_T_EPC   | trap: write mepc with the captured next_pc
//   S_T_CAUSE | trap: write mcause with the captured cause
//   S_T_STAT  | trap: write mstatus (MPIE<=MIE, MIE<=0, MPP<=M)
//   S_T_JUMP  | trap: redirect to the handler (direct or vectored)
//   S_M_STAT  | mret: write mstatus (MIE<=MPIE, MPIE<=1)
//   S_M_JUMP  | mret: redirect to mepc
module trap_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            t_irq,
    input  logic            s_irq,
    input  logic            e_irq,
    input  logic            commit,
    input  logic [XLEN-1:0] next_pc,
    input  logic            is_mret,
    input  logic [XLEN-1:0] mstatus_i,
    input  logic [XLEN-1:0] mie_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic [2:0]      mip_clr,
    output logic [XLEN-1:0] mip_o,
    output logic            stall,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [XLEN-1:0] MIP_MASK = XLEN'(32'h888);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T_EPC,
        S_T_CAUSE,
        S_T_STAT,
        S_T_JUMP,
        S_M_STAT,
        S_M_JUMP
    } state_t;

    logic [SYNC_STAGES-1:0][2:0] r_sync;
    logic [2:0]                  r_pend;
    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [XLEN-1:0]             r_epc;
    logic [3:0]                  r_cause;
    logic [2:0]                  w_irq_s;
    logic [XLEN-1:0]             w_en;
    logic                        w_take;
    logic [3:0]                  w_cause;
    logic [XLEN-1:0]             w_vec_base;
    logic [XLEN-1:0]             w_vec_off;

    assign w_irq_s    = r_sync[SYNC_STAGES-1];
    assign w_en       = mip_o & mie_i & MIP_MASK;
    assign w_take     = commit & ~is_mret & mstatus_i[3] & (|w_en);
    assign w_cause    = w_en[11] ? 4'd11 : (w_en[3] ? 4'd3 : 4'd7);
    assign w_vec_base = {mtvec_i[XLEN-1:2], 2'b00};
    assign w_vec_off  = {{(XLEN-6){1'b0}}, r_cause, 2'b00};

    // Synchroniser chains for {e,s,t}; the oldest stage feeds the pending bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], {e_irq, s_irq, t_irq}};
    end

    // Sticky pending bits; a synchronised request wins over a same-cycle W1C ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pend <= '0;
        else     r_pend <= (r_pend & ~mip_clr) | w_irq_s;
    end

    // Map the pending bits {e,s,t} onto their mip positions.
    always_comb begin
        mip_o     = '0;
        mip_o[3]  = r_pend[1];
        mip_o[7]  = r_pend[0];
        mip_o[11] = r_pend[2];
    end

    // Capture the return PC and cause when a trap is taken, so later changes to mip cannot alter it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_epc   <= '0;
            r_cause <= '0;
        end else if (r_state == S_IDLE && w_take) begin
            r_epc   <= next_pc;
            r_cause <= w_cause;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and outputs; the write bus reads zero unless a write is strobed.
    always_comb begin
        w_state_nxt = r_state;
        stall       = (r_state != S_IDLE);
        csr_we      = 1'b0;
        csr_waddr   = '0;
        csr_wdata   = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        case (r_state)
            S_IDLE: begin
                if (commit && is_mret) w_state_nxt = S_M_STAT;
                else if (w_take)       w_state_nxt = S_T_EPC;
            end
            S_T_EPC: begin
                csr_we      = 1'b1;
                csr_waddr   = 12'h341;
                csr_wdata   = r_epc;
                w_state_nxt = S_T_CAUSE;
            end
            S_T_CAUSE: begin
                csr_we               = 1'b1;
                csr_waddr            = 12'h342;
                csr_wdata[XLEN-1]    = 1'b1;
                csr_wdata[3:0]       = r_cause;
                w_state_nxt          = S_T_STAT;
            end
            S_T_STAT: begin
                csr_we          = 1'b1;
                csr_waddr       = 12'h300;
                csr_wdata       = mstatus_i;
                csr_wdata[7]    = mstatus_i[3];
                csr_wdata[3]    = 1'b0;
                csr_wdata[12:11] = 2'b11;
                w_state_nxt     = S_T_JUMP;
            end
            S_T_JUMP: begin
                redirect    = 1'b1;
                redirect_pc = (mtvec_i[1:0] == 2'b01) ? (w_vec_base + w_vec_off) : w_vec_base;
                w_state_nxt = S_IDLE;
            end
            S_M_STAT: begin
                csr_we       = 1'b1;
                csr_waddr    = 12'h300;
                csr_wdata    = mstatus_i;
                csr_wdata[3] = mstatus_i[7];
                csr_wdata[7] = 1'b1;
                w_state_nxt  = S_M_JUMP;
            end
            S_M_JUMP: begin
                redirect    = 1'b1;
                redirect_pc = mepc_i;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Testbench for trap_ctrl. A transaction-level reference model predicts, for each commit,
// the list of CSR writes, the redirect cycle and its target, and the mip contents.
module tb_trap_ctrl;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        t_irq = 1'b0, s_irq = 1'b0, e_irq = 1'b0;
    logic        commit = 1'b0, is_mret = 1'b0;
    logic [31:0] next_pc = '0;
    logic [2:0]  mip_clr = '0;
    logic [31:0] mip_o, csr_wdata, redirect_pc;
    logic        stall, csr_we, redirect;
    logic [11:0] csr_waddr;

    logic [31:0] m_status = '0, m_ie = '0, m_tvec = '0, m_epc = '0;
    logic [2:0]  m_pend = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.SYNC_STAGES(SYNC), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .t_irq(t_irq), .s_irq(s_irq), .e_irq(e_irq),
        .commit(commit), .next_pc(next_pc), .is_mret(is_mret),
        .mstatus_i(m_status), .mie_i(m_ie), .mtvec_i(m_tvec), .mepc_i(m_epc),
        .mip_clr(mip_clr), .mip_o(mip_o),
        .stall(stall), .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] mip_of(input logic [2:0] p);
        return (p[2] ? 32'h800 : 32'h0) | (p[1] ? 32'h8 : 32'h0) | (p[0] ? 32'h80 : 32'h0);
    endfunction

    // Pulse the selected requests {e,s,t} for one cycle and let them reach mip.
    task automatic pulse_irq(input logic [2:0] v);
        {e_irq, s_irq, t_irq} = v;
        step();
        {e_irq, s_irq, t_irq} = 3'b000;
        for (int i = 0; i < SYNC + 1; i++) step();
        m_pend = m_pend | v;
        chk("mip_after_irq", mip_o, mip_of(m_pend));
    endtask

    task automatic clear_pend(input logic [2:0] v);
        mip_clr = v;
        step();
        mip_clr = 3'b000;
        m_pend = m_pend & ~v;
        chk("mip_after_clr", mip_o, mip_of(m_pend));
    endtask

    // One commit at the current model CSR values; check the whole resulting sequence.
    task automatic do_commit(input logic mret, input logic [31:0] npc);
        logic [31:0] en;
        logic [3:0]  cause;
        logic [11:0] ea[3];
        logic [31:0] ed[3];
        logic [11:0] oa[4];
        logic [31:0] od[4];
        int          n_exp = 0, n_obs = 0, red_exp = 0, red_obs = 0, red_cnt = 0;
        int          stall_cnt = 0, zero_viol = 0;
        logic [31:0] pc_exp = '0, pc_obs = '0;
        logic [31:0] base;

        en = mip_of(m_pend) & m_ie & 32'h888;
        if (mret) begin
            n_exp   = 1;
            ea[0]   = 12'h300;
            ed[0]   = (m_status & ~32'h88) | 32'h80 | (m_status[7] ? 32'h8 : 32'h0);
            red_exp = 2;
            pc_exp  = m_epc;
        end else if (m_status[3] && en != 0) begin
            cause   = en[11] ? 4'd11 : (en[3] ? 4'd3 : 4'd7);
            n_exp   = 3;
            ea[0] = 12'h341; ed[0] = npc;
            ea[1] = 12'h342; ed[1] = 32'h8000_0000 + 32'(cause);
            ea[2] = 12'h300; ed[2] = (m_status & ~32'h1888) | 32'h1800 | (m_status[3] ? 32'h80 : 32'h0);
            red_exp = 4;
            base    = m_tvec & ~32'h3;
            pc_exp  = (m_tvec[1:0] == 2'b01) ? base + 32'(cause) * 4 : base;
        end

        commit  = 1'b1;
        is_mret = mret;
        next_pc = npc;
        for (int idx = 1; idx <= 6; idx++) begin
            step();
            commit  = 1'b0;
            is_mret = 1'b0;
            next_pc = $urandom;
            #1;
            if (stall) stall_cnt++;
            if (csr_we) begin
                if (n_obs < 4) begin
                    oa[n_obs] = csr_waddr;
                    od[n_obs] = csr_wdata;
                end
                n_obs++;
            end else if (csr_waddr != 0 || csr_wdata != 0) begin
                zero_viol++;
            end
            if (redirect) begin
                red_cnt++;
                if (red_obs == 0) begin
                    red_obs = idx;
                    pc_obs  = redirect_pc;
                end
            end
        end

        chk("n_writes", 32'(n_obs), 32'(n_exp));
        for (int i = 0; i < n_exp; i++) begin
            if (i < n_obs) begin
                chk("wr_addr", 32'(oa[i]), 32'(ea[i]));
                chk("wr_data", od[i], ed[i]);
            end
        end
        chk("redirect_cycle", 32'(red_obs), 32'(red_exp));
        chk("redirect_count", 32'(red_cnt), (red_exp != 0) ? 32'd1 : 32'd0);
        if (red_exp != 0) chk("redirect_pc", pc_obs, pc_exp);
        chk("stall_cycles", 32'(stall_cnt), 32'(red_exp));
        chk("bus_zero_idle", 32'(zero_viol), 32'd0);
        chk("mip_after_seq", mip_o, mip_of(m_pend));
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_we", 32'(csr_we), 32'd0);
        chk("rst_redirect", 32'(redirect), 32'd0);
        chk("rst_mip", mip_o, 32'd0);
        chk("rst_wdata", csr_wdata, 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        rst = 1'b0;
        step();

        // 1: direct-mode timer trap, including synchroniser latency
        m_status = 32'h8; m_ie = 32'h80; m_tvec = 32'h100;
        t_irq = 1'b1;
        step();
        t_irq = 1'b0;
        chk("sync_lat_1", mip_o, 32'h0);
        step();
        chk("sync_lat_2", mip_o, 32'h0);
        step();
        chk("sync_lat_3", mip_o, 32'h80);
        m_pend = 3'b001;
        do_commit(1'b0, 32'h40);
        clear_pend(3'b001);

        // 2: vectored, timer and external together -> cause 11, MTIP stays set
        m_status = 32'h8; m_ie = 32'h888; m_tvec = 32'h101;
        pulse_irq(3'b101);
        do_commit(1'b0, 32'h1234);
        chk("t2_mtip_kept", mip_o & 32'h80, 32'h80);
        clear_pend(3'b101);

        // 3: MIE=0 blocks the trap; enabling it takes the trap at the next commit
        m_status = 32'h0; m_ie = 32'h80; m_tvec = 32'h400;
        pulse_irq(3'b001);
        do_commit(1'b0, 32'h80);
        m_status = 32'h8;
        do_commit(1'b0, 32'h84);
        clear_pend(3'b001);

        // 4: mret wins over a pending external interrupt; trap at the following commit
        m_status = 32'h80; m_ie = 32'h800; m_tvec = 32'h300; m_epc = 32'h2000;
        pulse_irq(3'b100);
        do_commit(1'b1, 32'h500);
        m_status = 32'h88;
        do_commit(1'b0, 32'h2000);
        clear_pend(3'b100);

        // 5: reset in T_CAUSE aborts at once; set wins over a same-cycle clear
        m_status = 32'h8; m_ie = 32'h888; m_tvec = 32'h200;
        pulse_irq(3'b001);
        commit = 1'b1; next_pc = 32'h60;
        step();
        commit = 1'b0;
        step();
        chk("t5_pre_stall", 32'(stall), 32'd1);
        chk("t5_pre_addr", 32'(csr_waddr), 32'h342);
        #1 rst = 1'b1;
        #1;
        chk("t5_stall", 32'(stall), 32'd0);
        chk("t5_we", 32'(csr_we), 32'd0);
        chk("t5_redirect", 32'(redirect), 32'd0);
        chk("t5_mip", mip_o, 32'd0);
        step();
        rst = 1'b0;
        m_pend = 3'b000;
        step();
        chk("t5_idle", 32'(stall), 32'd0);
        e_irq = 1'b1;
        for (int i = 0; i < SYNC + 2; i++) step();
        m_pend = 3'b100;
        chk("t5_meip_set", mip_o, 32'h800);
        mip_clr = 3'b100;
        step();
        mip_clr = 3'b000;
        step();
        chk("t5_meip_held", mip_o, 32'h800);
        e_irq = 1'b0;
        for (int i = 0; i < SYNC + 1; i++) step();
        clear_pend(3'b100);

        // Randomized commits against the reference model
        for (int it = 0; it < 40; it++) begin
            logic [2:0] v;
            m_status = $urandom;
            m_ie     = $urandom;
            m_tvec   = $urandom;
            m_epc    = $urandom;
            v = 3'($urandom_range(0, 7));
            if (v != 0) pulse_irq(v);
            do_commit($urandom_range(0, 3) == 0, $urandom);
            clear_pend(3'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
